regfile_rename: RTL and testbench

Parametrised successor to the core's architectural register file. It holds the committed register values and also a per-register busy bit and ROB tag, the register result status. Dispatch reads operand values or producer tags through NREAD combinational ports, and sets busy and tag on the destination register. Commit writes the value back and clears busy only when the committing tag still owns the register. Flush clears all busy state after a misprediction.

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/regfile_read_port.sv | 53 +++++
 rtl/regfile_rename.sv | 104 ++++++++++
 tb/tb_regfile_rename.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and types for the renaming register file.
//   DATA_W / NREGS / TAG_W / NREAD : default parameter values
//   reg_addr_t, rob_tag_t, data_t  : widths at the default configuration
//   reg_status_t                   : register result status {busy, tag}
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int NREGS  = 32;
  localparam int TAG_W  = 4;
  localparam int NREAD  = 2;

  typedef logic [$clog2(NREGS)-1:0] reg_addr_t;
  typedef logic [TAG_W-1:0]         rob_tag_t;
  typedef logic [DATA_W-1:0]        data_t;

  typedef struct packed {
    logic     busy;
    rob_tag_t tag;
  } reg_status_t;

endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read port of regfile_rename.
// Takes the already-selected stored value/status for addr_i and applies:
//   - register 0 override (always reads 0, not busy, tag 0)
//   - commit bypass: same-cycle commit data replaces the stored value, and
//     clears busy/tag only when the committing tag owns the register.
// Ports:
//   addr_i        register address of this port
//   value_i       stored value of that register
//   busy_i/tag_i  stored result status of that register
//   commit_*_i    current-cycle commit request
//   data_o/busy_o/tag_o  port outputs
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int TAG_W  = regfile_pkg::TAG_W,
  parameter int AW     = $clog2(regfile_pkg::NREGS)
) (
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] value_i,
  input  logic              busy_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic              commit_en_i,
  input  logic [AW-1:0]     commit_addr_i,
  input  logic [TAG_W-1:0]  commit_tag_i,
  input  logic [DATA_W-1:0] commit_data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o,
  output logic [TAG_W-1:0]  tag_o
);

  logic hit;
  logic owner;

  // Any commit to this register forwards its data; only the owning tag
  // also retires the busy state.
  assign hit   = commit_en_i && (commit_addr_i == addr_i);
  assign owner = hit && busy_i && (tag_i == commit_tag_i);

  always_comb begin
    data_o = '0;
    busy_o = 1'b0;
    tag_o  = '0;
    if (addr_i != '0) begin
      data_o = hit ? commit_data_i : value_i;
      if (busy_i && !owner) begin
        busy_o = 1'b1;
        tag_o  = tag_i;
      end
    end
  end

endmodule

// File: rtl/regfile_rename.sv
// regfile_rename: architectural register file with per-register result
// status (busy bit + ROB tag of the in-flight producer).
// Ports:
//   clk, reset                         clock, async active-high reset
//   rdAddr / rdData / rdBusy / rdTag   NREAD combinational read ports
//   renameEn / renameAddr / renameTag  dispatch claims a destination
//   commitEn / commitAddr / commitTag / commitData  ROB writes back
//   flush                              clear all busy state
module regfile_rename
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int NREGS  = regfile_pkg::NREGS,
  parameter int TAG_W  = regfile_pkg::TAG_W,
  parameter int NREAD  = regfile_pkg::NREAD,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NREAD-1:0][AW-1:0]      rdAddr,
  output logic [NREAD-1:0][DATA_W-1:0]  rdData,
  output logic [NREAD-1:0]              rdBusy,
  output logic [NREAD-1:0][TAG_W-1:0]   rdTag,
  input  logic                          renameEn,
  input  logic [AW-1:0]                 renameAddr,
  input  logic [TAG_W-1:0]              renameTag,
  input  logic                          commitEn,
  input  logic [AW-1:0]                 commitAddr,
  input  logic [TAG_W-1:0]              commitTag,
  input  logic [DATA_W-1:0]             commitData,
  input  logic                          flush
);

  logic [NREGS-1:0][DATA_W-1:0] value_q, value_d;
  logic [NREGS-1:0]             busy_q,  busy_d;
  logic [NREGS-1:0][TAG_W-1:0]  tag_q,   tag_d;

  logic cmt_ok, ren_ok, cmt_owner;

  // Writes to register 0 are dropped so its storage stays at reset value.
  assign cmt_ok    = commitEn && (commitAddr != '0);
  assign ren_ok    = renameEn && (renameAddr != '0);
  assign cmt_owner = cmt_ok && busy_q[commitAddr] && (tag_q[commitAddr] == commitTag);

  always_comb begin
    value_d = value_q;
    busy_d  = busy_q;
    tag_d   = tag_q;

    // Value write-back is unconditional: even a stale commit carries the
    // architecturally correct value for its point in program order.
    if (cmt_ok) value_d[commitAddr] = commitData;

    if (flush) begin
      busy_d = '0;
      tag_d  = '0;
    end else begin
      if (cmt_owner) begin
        busy_d[commitAddr] = 1'b0;
        tag_d[commitAddr]  = '0;
      end
      // Applied after the commit so a same-register rename keeps busy set
      // and takes over ownership.
      if (ren_ok) begin
        busy_d[renameAddr] = 1'b1;
        tag_d[renameAddr]  = renameTag;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
      busy_q  <= '0;
      tag_q   <= '0;
    end else begin
      value_q <= value_d;
      busy_q  <= busy_d;
      tag_q   <= tag_d;
    end
  end

  // Reads see registered state only; rename and flush are not forwarded.
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    regfile_read_port #(
      .DATA_W (DATA_W),
      .TAG_W  (TAG_W),
      .AW     (AW)
    ) u_rp (
      .addr_i        (rdAddr[i]),
      .value_i       (value_q[rdAddr[i]]),
      .busy_i        (busy_q[rdAddr[i]]),
      .tag_i         (tag_q[rdAddr[i]]),
      .commit_en_i   (commitEn),
      .commit_addr_i (commitAddr),
      .commit_tag_i  (commitTag),
      .commit_data_i (commitData),
      .data_o        (rdData[i]),
      .busy_o        (rdBusy[i]),
      .tag_o         (rdTag[i])
    );
  end

endmodule

// File: tb/tb_regfile_rename.sv
module tb_regfile_rename;
  import regfile_pkg::*;

  localparam int AW = $clog2(NREGS);

  logic                         clk = 1'b0;
  logic                         reset;
  logic [NREAD-1:0][AW-1:0]     rdAddr;
  logic [NREAD-1:0][DATA_W-1:0] rdData;
  logic [NREAD-1:0]             rdBusy;
  logic [NREAD-1:0][TAG_W-1:0]  rdTag;
  logic                         renameEn;
  logic [AW-1:0]                renameAddr;
  logic [TAG_W-1:0]             renameTag;
  logic                         commitEn;
  logic [AW-1:0]                commitAddr;
  logic [TAG_W-1:0]             commitTag;
  logic [DATA_W-1:0]            commitData;
  logic                         flush;

  int n_vec = 0;
  int n_err = 0;

  regfile_rename dut (
    .clk(clk), .reset(reset),
    .rdAddr(rdAddr), .rdData(rdData), .rdBusy(rdBusy), .rdTag(rdTag),
    .renameEn(renameEn), .renameAddr(renameAddr), .renameTag(renameTag),
    .commitEn(commitEn), .commitAddr(commitAddr), .commitTag(commitTag),
    .commitData(commitData), .flush(flush)
  );

  always #5 clk = ~clk;

  // Inputs for one cycle plus the expected same-cycle read results.
  typedef struct {
    string       name;
    logic        ren;  logic [AW-1:0] raddr; logic [TAG_W-1:0] rtag;
    logic        cen;  logic [AW-1:0] caddr; logic [TAG_W-1:0] ctag;
    logic [DATA_W-1:0] cdata;
    logic        fl;
    logic [AW-1:0] a0, a1;
    data_t       d0;   reg_status_t s0;
    data_t       d1;   reg_status_t s1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input string nm,
    input logic ren, input int raddr, input int rtag,
    input logic cen, input int caddr, input int ctag, input logic [31:0] cdata,
    input logic fl, input int a0, input int a1,
    input logic [31:0] d0, input logic b0, input int t0,
    input logic [31:0] d1, input logic b1, input int t1);
    vec_t v;
    v.name = nm;
    v.ren = ren; v.raddr = AW'(raddr); v.rtag = TAG_W'(rtag);
    v.cen = cen; v.caddr = AW'(caddr); v.ctag = TAG_W'(ctag); v.cdata = cdata;
    v.fl = fl; v.a0 = AW'(a0); v.a1 = AW'(a1);
    v.d0 = d0; v.s0.busy = b0; v.s0.tag = TAG_W'(t0);
    v.d1 = d1; v.s1.busy = b1; v.s1.tag = TAG_W'(t1);
    return v;
  endfunction

  task automatic idle();
    renameEn = 0; renameAddr = '0; renameTag = '0;
    commitEn = 0; commitAddr = '0; commitTag = '0; commitData = '0;
    flush = 0;
  endtask

  task automatic chk(input string nm, input int p, input data_t ed, input logic eb,
                     input logic [TAG_W-1:0] et);
    n_vec++;
    if (rdData[p] !== ed || rdBusy[p] !== eb || rdTag[p] !== et) begin
      n_err++;
      $display("FAIL %s port%0d: got data=%h busy=%b tag=%h, expected data=%h busy=%b tag=%h",
               nm, p, rdData[p], rdBusy[p], rdTag[p], ed, eb, et);
    end
  endtask

  initial begin
    idle();
    rdAddr = '0;
    reset = 1'b1;
    #1;
    chk("reset_r0", 0, '0, 1'b0, '0);
    chk("reset_r0", 1, '0, 1'b0, '0);
    @(negedge clk);
    reset = 1'b0;

    // Every register clean after reset, both ports.
    for (int r = 0; r < NREGS; r++) begin
      rdAddr[0] = AW'(r);
      rdAddr[1] = AW'(NREGS - 1 - r);
      #1;
      chk($sformatf("reset_r%0d", r), 0, '0, 1'b0, '0);
      chk($sformatf("reset_r%0d", NREGS - 1 - r), 1, '0, 1'b0, '0);
    end

    //               name          ren ra rt  cen ca ct cdata   fl a0 a1  d0 b0 t0  d1 b1 t1
    vecs.push_back(mk("idle",        0, 0, 0,  0, 0, 0, 32'h0,  0, 5, 0,  0, 0, 0,  0, 0, 0));
    vecs.push_back(mk("ren5_t3",     1, 5, 3,  0, 0, 0, 32'h0,  0, 5, 6,  0, 0, 0,  0, 0, 0));
    vecs.push_back(mk("r5_busy",     0, 0, 0,  0, 0, 0, 32'h0,  0, 5, 0,  0, 1, 3,  0, 0, 0));
    vecs.push_back(mk("cmt5_byp",    0, 0, 0,  1, 5, 3, 32'd5,  0, 5, 1,  5, 0, 0,  0, 0, 0));
    vecs.push_back(mk("r5_after",    0, 0, 0,  0, 0, 0, 32'h0,  0, 5, 5,  5, 0, 0,  5, 0, 0));
    vecs.push_back(mk("ren5_t3b",    1, 5, 3,  0, 0, 0, 32'h0,  0, 5, 0,  5, 0, 0,  0, 0, 0));
    vecs.push_back(mk("ren5_t7",     1, 5, 7,  0, 0, 0, 32'h0,  0, 5, 0,  5, 1, 3,  0, 0, 0));
    vecs.push_back(mk("cmt5_stale",  0, 0, 0,  1, 5, 3, 32'd9,  0, 5, 0,  9, 1, 7,  0, 0, 0));
    vecs.push_back(mk("r5_t7",       0, 0, 0,  0, 0, 0, 32'h0,  0, 5, 0,  9, 1, 7,  0, 0, 0));
    vecs.push_back(mk("ren6_pre",    1, 6, 2,  0, 0, 0, 32'h0,  0, 6, 5,  0, 0, 0,  9, 1, 7));
    vecs.push_back(mk("r6_busy",     0, 0, 0,  0, 0, 0, 32'h0,  0, 6, 5,  0, 1, 2,  9, 1, 7));
    vecs.push_back(mk("ren8_t4",     1, 8, 4,  0, 0, 0, 32'h0,  0, 8, 0,  0, 0, 0,  0, 0, 0));
    vecs.push_back(mk("flush_mix",   1, 7, 1,  1, 8, 4, 32'd30, 1, 8, 7, 30, 0, 0,  0, 0, 0));
    vecs.push_back(mk("post_flush",  0, 0, 0,  0, 0, 0, 32'h0,  0, 8, 7, 30, 0, 0,  0, 0, 0));
    vecs.push_back(mk("flush_r5r6",  0, 0, 0,  0, 0, 0, 32'h0,  0, 5, 6,  9, 0, 0,  0, 0, 0));
    vecs.push_back(mk("r0_writes",   1, 0, 5,  1, 0, 0, 32'd77, 0, 0, 0,  0, 0, 0,  0, 0, 0));
    vecs.push_back(mk("r0_after",    0, 0, 0,  0, 0, 0, 32'h0,  0, 0, 0,  0, 0, 0,  0, 0, 0));
    vecs.push_back(mk("cmt9_idle",   0, 0, 0,  1, 9, 0, 32'h55, 0, 9, 0, 32'h55, 0, 0, 0, 0, 0));
    vecs.push_back(mk("r9_after",    0, 0, 0,  0, 0, 0, 32'h0,  0, 9, 0, 32'h55, 0, 0, 0, 0, 0));
    vecs.push_back(mk("ren10_t6",    1,10, 6,  0, 0, 0, 32'h0,  0,10, 0,  0, 0, 0,  0, 0, 0));
    vecs.push_back(mk("ren_cmt10",   1,10, 5,  1,10, 6, 32'hAA, 0,10,10, 32'hAA,0,0, 32'hAA,0,0));
    vecs.push_back(mk("r10_t5",      0, 0, 0,  0, 0, 0, 32'h0,  0,10, 9, 32'hAA,1,5, 32'h55,0,0));

    foreach (vecs[i]) begin
      @(negedge clk);
      renameEn = vecs[i].ren; renameAddr = vecs[i].raddr; renameTag = vecs[i].rtag;
      commitEn = vecs[i].cen; commitAddr = vecs[i].caddr; commitTag = vecs[i].ctag;
      commitData = vecs[i].cdata; flush = vecs[i].fl;
      rdAddr[0] = vecs[i].a0; rdAddr[1] = vecs[i].a1;
      #1;
      chk(vecs[i].name, 0, vecs[i].d0, vecs[i].s0.busy, vecs[i].s0.tag);
      chk(vecs[i].name, 1, vecs[i].d1, vecs[i].s1.busy, vecs[i].s1.tag);
    end

    // Mid-run async reset: outputs clear with no clock edge in between.
    @(negedge clk);
    idle();
    rdAddr[0] = AW'(10); rdAddr[1] = AW'(9);
    reset = 1'b1;
    #1;
    chk("async_rst", 0, '0, 1'b0, '0);
    chk("async_rst", 1, '0, 1'b0, '0);
    #1 reset = 1'b0;

    // First edge after release updates state normally.
    @(negedge clk);
    renameEn = 1; renameAddr = AW'(3); renameTag = TAG_W'(9);
    @(negedge clk);
    idle();
    rdAddr[0] = AW'(3); rdAddr[1] = AW'(10);
    #1;
    chk("post_rst_ren", 0, '0, 1'b1, TAG_W'(9));
    chk("post_rst_ren", 1, '0, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
